decode: RTL and testbench
=========================

DECODE -- requirements
Module: decode

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: fetchoutput  input  32  [31:16] current word, [15:0] next word, both from the fetch stage.
REQ-004 SHALL have port: pcjumpenable  output  3  jump request to fetch: 0 none, 1 relative, 2 absolute, 3 absolute+link, 4 relative+link.
REQ-005 SHALL have port: pcchange  output  9  relative offset, from word bits [8:0].
REQ-006 SHALL have port: pclocation  output  6  absolute target, from word bits [5:0].
REQ-007 SHALL have port: flush  output  1  request to zero the fetch stage's current-word register.
REQ-008 SHALL have ports: valid 1, cls 2, opcode 4, rd 6, ra 6, rb 6, imm 16, illegal 1, all outputs to execute.

Function
REQ-009 Word format SHALL be: [15] ext (32-bit instruction), [14:13] class (00 ALU, 01 branch, 10 mem, 11 misc), [12:9] opcode, [8:6] rd, [5:3] ra, [2:0] rb.
REQ-010 All outputs SHALL be registered; decode result appears 1 cycle after fetchoutput is sampled.
REQ-011 FSM states SHALL be PRIME, RUN, EXT, JHOLD1, JHOLD2.
REQ-012 PRIME SHALL last 2 cycles after reset with valid=0, fetchoutput ignored, then go to RUN.
REQ-013 In RUN, current word 0x0000 SHALL be a bubble: valid=0.
REQ-014 In RUN, 16-bit non-branch: valid=1; rd/ra/rb = 3-bit fields zero-extended; imm=0.
REQ-015 In RUN, ext=1 non-branch: valid=1; imm = next word; go to EXT.
REQ-016 EXT SHALL last 1 cycle with valid=0 to discard the consumed second word, then go to RUN.
REQ-017 In RUN, branch class: opcode 0..3 SHALL drive pcjumpenable 1..4 respectively; pcchange and pclocation are loaded; valid=1; go to JHOLD1.
REQ-018 A branch with ext=1 SHALL ignore the second word and follow REQ-017.
REQ-019 pcjumpenable, pcchange and pclocation SHALL hold for exactly 2 cycles (JHOLD1, JHOLD2); in both cycles valid=0 and fetchoutput is ignored.
REQ-020 flush SHALL be 1 in JHOLD2 only; the state after JHOLD2 SHALL be RUN with pcjumpenable=0.
REQ-021 Branch opcode 4..15 SHALL be treated as illegal: pcjumpenable=0, valid=1, no JHOLD.
REQ-022 Misc class opcode >= 8 SHALL be illegal (see REQ-027).

Reset
REQ-023 Reset SHALL be sampled on the clock edge only and override every state.
REQ-024 Reset values SHALL be: state PRIME, all outputs 0, including pcjumpenable=0 and flush=0.
REQ-025 Reset asserted in JHOLD1 or JHOLD2 SHALL drop pcjumpenable to 0 on the next edge; the pending jump is abandoned.

Configuration
REQ-026 Macro DECODE_ILLEGAL_TRAP_EN SHALL gate illegal-instruction detection.
REQ-027 With the macro defined: illegal=1 alongside valid=1 for illegal words (REQ-021, REQ-022). Without it: illegal tied 0, and those words decode as ordinary instructions.

Structure
REQ-028 Package decode_pkg SHALL hold class codes, jump codes JE_NONE..JE_BAL (0..4), FSM state encoding and word-field bit positions.
REQ-029 Field extraction SHALL be one combinational sub-module, decode_fields; FSM and output registers stay in decode.

Verification
REQ-030 Reset, then fetchoutput=0x0000_0000 for 3 cycles -> valid=0 throughout; all outputs 0.
REQ-031 RUN, fetchoutput=0x0A53_xxxx (ALU op5 rd1 ra2 rb3) -> next cycle valid=1, opcode=5, rd=1, ra=2, rb=3, imm=0.
REQ-032 RUN, fetchoutput=0x8200_1234 -> valid=1, imm=0x1234; next cycle valid=0 (EXT); then RUN.
REQ-033 RUN, fetchoutput=0x2215_xxxx (branch op1, [8:0]=0x015) -> pcjumpenable=2 and pclocation=0x15 for 2 cycles, flush=1 in the second, then pcjumpenable=0.
REQ-034 Relative branch 0x2005 accepted, reset in JHOLD1 -> next edge pcjumpenable=0, valid=0, state PRIME.
REQ-035 With DECODE_ILLEGAL_TRAP_EN, word 0x7000 -> valid=1, illegal=1; without the macro -> illegal=0.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the decode stage.
//   - instruction class codes and fetch jump-request codes
//   - FSM state encoding
//   - bit positions of the 16-bit instruction word fields
//   - fields_t: the extracted fields handed from decode_fields to decode
//   - branch_je(): maps a legal branch opcode (0..3) to its jump code (1..4)
package decode_pkg;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'b00,
    CLS_BR   = 2'b01,
    CLS_MEM  = 2'b10,
    CLS_MISC = 2'b11
  } cls_e;

  typedef enum logic [2:0] {
    JE_NONE = 3'd0,
    JE_REL  = 3'd1,
    JE_ABS  = 3'd2,
    JE_AL   = 3'd3,
    JE_BAL  = 3'd4
  } je_e;

  typedef enum logic [2:0] {
    ST_PRIME,
    ST_RUN,
    ST_EXT,
    ST_JHOLD1,
    ST_JHOLD2
  } state_e;

  // Word field bit positions
  localparam int unsigned EXT_BIT = 15;
  localparam int unsigned CLS_HI  = 14;
  localparam int unsigned CLS_LO  = 13;
  localparam int unsigned OP_HI   = 12;
  localparam int unsigned OP_LO   = 9;
  localparam int unsigned RD_HI   = 8;
  localparam int unsigned RD_LO   = 6;
  localparam int unsigned RA_HI   = 5;
  localparam int unsigned RA_LO   = 3;
  localparam int unsigned RB_HI   = 2;
  localparam int unsigned RB_LO   = 0;
  localparam int unsigned PCC_HI  = 8;
  localparam int unsigned PCL_HI  = 5;

  typedef struct packed {
    logic [15:0] word;
    logic        ext;
    cls_e        cls;
    logic [3:0]  opcode;
    logic [2:0]  rd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [8:0]  pcchange;
    logic [5:0]  pclocation;
    logic [15:0] next;
  } fields_t;

  function automatic je_e branch_je(input logic [3:0] op);
    return je_e'({1'b0, op[1:0]} + 3'd1);
  endfunction

endpackage

// File: rtl/decode_if.sv
// decode_if: decode -> execute result bundle.
//   valid   : result is a real instruction
//   cls     : instruction class
//   opcode  : 4-bit opcode
//   rd/ra/rb: register numbers, zero-extended to 6 bits
//   imm     : immediate (second word of an extended instruction, else 0)
//   illegal : illegal-instruction flag (meaningful only with valid)
// modport master drives the bundle (decode), slave receives it (execute).
interface decode_if;
  logic        valid;
  logic [1:0]  cls;
  logic [3:0]  opcode;
  logic [5:0]  rd;
  logic [5:0]  ra;
  logic [5:0]  rb;
  logic [15:0] imm;
  logic        illegal;

  modport master (output valid, cls, opcode, rd, ra, rb, imm, illegal);
  modport slave  (input  valid, cls, opcode, rd, ra, rb, imm, illegal);
endinterface

// File: rtl/decode_fields.sv
// decode_fields: purely combinational field extraction for the decode stage.
//   i_fetch    : [31:16] current word, [15:0] next word
//   o_fields   : extracted fields of the current word plus the next word
//   o_br_jump  : current word is a branch with a jump opcode (0..3)
//   o_illegal  : illegal-instruction detect; only active when the build
//                defines DECODE_ILLEGAL_TRAP_EN, otherwise tied 0
module decode_fields
  import decode_pkg::*;
(
  input  logic [31:0] i_fetch,
  output fields_t     o_fields,
  output logic        o_br_jump,
  output logic        o_illegal
);

  logic [15:0] w_word;

  assign w_word = i_fetch[31:16];

  assign o_fields.word       = w_word;
  assign o_fields.ext        = w_word[EXT_BIT];
  assign o_fields.cls        = cls_e'(w_word[CLS_HI:CLS_LO]);
  assign o_fields.opcode     = w_word[OP_HI:OP_LO];
  assign o_fields.rd         = w_word[RD_HI:RD_LO];
  assign o_fields.ra         = w_word[RA_HI:RA_LO];
  assign o_fields.rb         = w_word[RB_HI:RB_LO];
  assign o_fields.pcchange   = w_word[PCC_HI:0];
  assign o_fields.pclocation = w_word[PCL_HI:0];
  assign o_fields.next       = i_fetch[15:0];

  assign o_br_jump = (o_fields.cls == CLS_BR) && (o_fields.opcode[3:2] == 2'b00);

`ifdef DECODE_ILLEGAL_TRAP_EN
  // Branch opcodes 4..15 and misc opcodes 8..15 have no defined meaning.
  assign o_illegal = ((o_fields.cls == CLS_BR)   && (o_fields.opcode[3:2] != 2'b00)) ||
                     ((o_fields.cls == CLS_MISC) &&  o_fields.opcode[3]);
`else
  assign o_illegal = 1'b0;
`endif

endmodule

// File: rtl/decode.sv
// decode: instruction decode stage between fetch and execute.
// Ports:
//   clock        : single clock, rising edge
//   reset        : synchronous, active-high
//   fetchoutput  : [31:16] current word, [15:0] next word from fetch
//   pcjumpenable : jump request to fetch (0 none, 1 rel, 2 abs, 3 abs+link, 4 rel+link)
//   pcchange     : relative jump offset (word bits [8:0])
//   pclocation   : absolute jump target (word bits [5:0])
//   flush        : zero the fetch stage's current-word register
//   ex           : decode_if.master result bundle to execute
// Build option: DECODE_ILLEGAL_TRAP_EN enables illegal-instruction flagging.
// All outputs are registered; a decode result appears one cycle after the
// word is sampled.
module decode
  import decode_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fetchoutput,
  output logic [2:0]  pcjumpenable,
  output logic [8:0]  pcchange,
  output logic [5:0]  pclocation,
  output logic        flush,
  decode_if.master    ex
);

  fields_t w_f;
  logic    w_br_jump;
  logic    w_illegal;

  decode_fields u_fields (
    .i_fetch   (fetchoutput),
    .o_fields  (w_f),
    .o_br_jump (w_br_jump),
    .o_illegal (w_illegal)
  );

  state_e      r_state;
  logic        r_prime_cnt;
  je_e         r_pje;
  logic [8:0]  r_pcchange;
  logic [5:0]  r_pclocation;
  logic        r_flush;
  logic        r_valid;
  logic [1:0]  r_cls;
  logic [3:0]  r_opcode;
  logic [5:0]  r_rd;
  logic [5:0]  r_ra;
  logic [5:0]  r_rb;
  logic [15:0] r_imm;
  logic        r_illegal;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_PRIME;
      r_prime_cnt  <= 1'b0;
      r_pje        <= JE_NONE;
      r_pcchange   <= '0;
      r_pclocation <= '0;
      r_flush      <= 1'b0;
      r_valid      <= 1'b0;
      r_cls        <= '0;
      r_opcode     <= '0;
      r_rd         <= '0;
      r_ra         <= '0;
      r_rb         <= '0;
      r_imm        <= '0;
      r_illegal    <= 1'b0;
    end else begin
      // Execute-side outputs describe only the word decoded at this edge;
      // every cycle without a fresh instruction presents an all-zero result.
      r_valid   <= 1'b0;
      r_cls     <= '0;
      r_opcode  <= '0;
      r_rd      <= '0;
      r_ra      <= '0;
      r_rb      <= '0;
      r_imm     <= '0;
      r_illegal <= 1'b0;
      r_flush   <= 1'b0;

      case (r_state)
        ST_PRIME: begin
          r_prime_cnt <= 1'b1;
          if (r_prime_cnt) r_state <= ST_RUN;
        end

        ST_RUN: begin
          if (w_f.word != 16'h0000) begin
            r_valid   <= 1'b1;
            r_cls     <= w_f.cls;
            r_opcode  <= w_f.opcode;
            r_rd      <= {3'b000, w_f.rd};
            r_ra      <= {3'b000, w_f.ra};
            r_rb      <= {3'b000, w_f.rb};
            r_illegal <= w_illegal;
            if (w_f.cls == CLS_BR) begin
              // Branches never consume a second word, even with ext set.
              if (w_br_jump) begin
                r_pje        <= branch_je(w_f.opcode);
                r_pcchange   <= w_f.pcchange;
                r_pclocation <= w_f.pclocation;
                r_state      <= ST_JHOLD1;
              end
            end else if (w_f.ext) begin
              r_imm   <= w_f.next;
              r_state <= ST_EXT;
            end
          end
        end

        ST_EXT: r_state <= ST_RUN;

        ST_JHOLD1: begin
          r_flush <= 1'b1;
          r_state <= ST_JHOLD2;
        end

        ST_JHOLD2: begin
          r_pje        <= JE_NONE;
          r_pcchange   <= '0;
          r_pclocation <= '0;
          r_state      <= ST_RUN;
        end

        default: r_state <= ST_PRIME;
      endcase
    end
  end

  assign pcjumpenable = r_pje;
  assign pcchange     = r_pcchange;
  assign pclocation   = r_pclocation;
  assign flush        = r_flush;

  assign ex.valid   = r_valid;
  assign ex.cls     = r_cls;
  assign ex.opcode  = r_opcode;
  assign ex.rd      = r_rd;
  assign ex.ra      = r_ra;
  assign ex.rb      = r_rb;
  assign ex.imm     = r_imm;
  assign ex.illegal = r_illegal;

endmodule

// File: tb/tb_decode.sv
// tb_decode: self-checking bench for decode. A cycle-level behavioural model
// (counters of ignored cycles and pending jump-hold cycles) predicts every
// output after every clock edge; directed words pin the model with literal
// expectations, then randomized words and occasional resets follow.
module tb_decode;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fetchoutput = '0;
  logic [2:0]  pcjumpenable;
  logic [8:0]  pcchange;
  logic [5:0]  pclocation;
  logic        flush;

  decode_if u_if ();

  decode dut (
    .clock        (clock),
    .reset        (reset),
    .fetchoutput  (fetchoutput),
    .pcjumpenable (pcjumpenable),
    .pcchange     (pcchange),
    .pclocation   (pclocation),
    .flush        (flush),
    .ex           (u_if)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: cycles whose input is ignored, and remaining jump-hold edges.
  int         m_ignore = 0;
  int         m_hold   = 0;
  logic [2:0] m_je;
  logic [8:0] m_pcc;
  logic [5:0] m_pcl;

  function automatic logic [60:0] dut_vec();
    return {u_if.valid, u_if.cls, u_if.opcode, u_if.rd, u_if.ra, u_if.rb,
            u_if.imm, u_if.illegal, pcjumpenable, pcchange, pclocation, flush};
  endfunction

  task automatic model_step(input logic r, input logic [31:0] w, output logic [60:0] e);
    logic        v, ill, fl;
    logic [1:0]  cls;
    logic [3:0]  opc;
    logic [5:0]  rd, ra, rb, pcl;
    logic [15:0] imm, cur, nxt;
    logic [2:0]  je;
    logic [8:0]  pcc;
    v = 0; ill = 0; fl = 0; cls = 0; opc = 0; rd = 0; ra = 0; rb = 0;
    imm = 0; je = 0; pcc = 0; pcl = 0;
    cur = w[31:16];
    nxt = w[15:0];
    if (r) begin
      m_ignore = 2;
      m_hold   = 0;
    end else if (m_hold == 2) begin
      je = m_je; pcc = m_pcc; pcl = m_pcl; fl = 1'b1;
      m_hold = 1;
    end else if (m_hold == 1) begin
      m_hold = 0;
    end else if (m_ignore > 0) begin
      m_ignore = m_ignore - 1;
    end else if (cur != 16'h0000) begin
      v   = 1'b1;
      cls = cur[14:13];
      opc = cur[12:9];
      rd  = {3'b000, cur[8:6]};
      ra  = {3'b000, cur[5:3]};
      rb  = {3'b000, cur[2:0]};
      if (cls == 2'd1) begin
        if (opc < 4'd4) begin
          je  = 3'(opc[1:0]) + 3'd1;
          pcc = cur[8:0];
          pcl = cur[5:0];
          m_je = je; m_pcc = pcc; m_pcl = pcl;
          m_hold = 2;
        end else begin
          ill = TRAP;
        end
      end else begin
        if (cls == 2'd3 && opc >= 4'd8) ill = TRAP;
        if (cur[15]) begin
          imm = nxt;
          m_ignore = 1;
        end
      end
    end
    e = {v, cls, opc, rd, ra, rb, imm, ill, je, pcc, pcl, fl};
  endtask

  task automatic step(input logic r, input logic [31:0] w, input string nm);
    logic [60:0] exp;
    reset       = r;
    fetchoutput = w;
    model_step(r, w, exp);
    @(posedge clock);
    #1;
    n_checks++;
    if (dut_vec() !== exp) begin
      n_fail++;
      $display("FAIL %s: dut=%h model=%h (fetchoutput=%h reset=%b)", nm, dut_vec(), exp, w, r);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  initial begin
    logic [31:0] w;
    logic        r;

    // Reset state
    step(1'b1, 32'h0, "reset0");
    step(1'b1, 32'hFFFF_FFFF, "reset1");
    chk("rst_valid", 32'(u_if.valid), 32'd0);
    chk("rst_pje", 32'(pcjumpenable), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);

    // Prime period plus one bubble in RUN: all zero
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, "prime_bubble");
      chk("prime_valid", 32'(u_if.valid), 32'd0);
    end

    // ALU op5 rd1 ra2 rb3
    step(1'b0, 32'h0A53_BEEF, "alu");
    chk("alu_valid", 32'(u_if.valid), 32'd1);
    chk("alu_opcode", 32'(u_if.opcode), 32'd5);
    chk("alu_regs", {8'h0, u_if.rd, u_if.ra, u_if.rb}, {8'h0, 6'd1, 6'd2, 6'd3});
    chk("alu_imm", 32'(u_if.imm), 32'd0);

    // Extended ALU: imm = next word, then one discarded cycle
    step(1'b0, 32'h8200_1234, "ext");
    chk("ext_imm", {15'h0, u_if.valid, u_if.imm}, {15'h0, 1'b1, 16'h1234});
    step(1'b0, 32'h0A53_0000, "ext_discard");
    chk("ext_discard_valid", 32'(u_if.valid), 32'd0);
    step(1'b0, 32'h0A53_0000, "ext_back_run");
    chk("ext_back_valid", 32'(u_if.valid), 32'd1);

    // Absolute branch: two hold cycles, flush in the second
    step(1'b0, 32'h2215_0000, "br_abs");
    chk("br_abs_pje", 32'(pcjumpenable), 32'd2);
    chk("br_abs_loc", {pcchange, pclocation}, {23'h0, 9'h015, 6'h15} & 32'h7FFF);
    chk("br_abs_flush0", {u_if.valid, flush}, 32'b10);
    step(1'b0, 32'h0A53_0000, "jhold1");
    chk("jhold1_pje_flush", {pcjumpenable, u_if.valid, flush}, {27'h0, 3'd2, 1'b0, 1'b1});
    step(1'b0, 32'h0A53_0000, "jhold2");
    chk("jhold2_pje_flush", {pcjumpenable, u_if.valid, flush}, 32'd0);
    step(1'b0, 32'h0A53_0000, "after_jump");
    chk("after_jump_valid", 32'(u_if.valid), 32'd1);

    // Relative branch, reset lands in JHOLD1
    step(1'b0, 32'h2005_0000, "br_rel");
    chk("br_rel_pje", 32'(pcjumpenable), 32'd1);
    chk("br_rel_pcc", 32'(pcchange), 32'h005);
    step(1'b1, 32'h0A53_0000, "reset_in_jhold");
    chk("rst_jhold_pje", {pcjumpenable, u_if.valid}, 32'd0);
    step(1'b0, 32'h0A53_0000, "prime_a");
    step(1'b0, 32'h0A53_0000, "prime_b");
    chk("prime_after_jrst", 32'(u_if.valid), 32'd0);

    // Misc opcode 8
    step(1'b0, 32'h7000_0000, "misc_illegal");
    chk("misc8_valid", 32'(u_if.valid), 32'd1);
    chk("misc8_illegal", 32'(u_if.illegal), 32'(TRAP));

    // Illegal branch opcode: no jump, stays in RUN
    step(1'b0, 32'h2800_0000, "br_op4");
    chk("br_op4_pje", {pcjumpenable, u_if.valid, u_if.illegal}, {27'h0, 3'd0, 1'b1, TRAP});
    step(1'b0, 32'h0A53_0000, "br_op4_next");
    chk("br_op4_next_valid", 32'(u_if.valid), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      w = $urandom;
      if ($urandom_range(0, 7) == 0) w[31:16] = 16'h0000;
      r = ($urandom_range(0, 99) == 0);
      step(r, w, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
